// File: rtl/serial_priority_encoder.sv
// ============================================================================
// serial_priority_encoder : streams the index of every set bit, lowest first
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_priority_encoder #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 out_none
);

  localparam int W = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t         state_q;
  logic [N-1:0]   mask_q;
  logic [N-1:0]   w_mask_clr;
  logic [W-1:0]   w_idx;
  logic           w_single;
  logic           w_empty;
  logic           w_emit;

  // Scan from the top so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        w_idx = W'(i);
      end
    end
  end

  assign w_mask_clr = mask_q & (mask_q - N'(1));
  assign w_empty    = (mask_q == '0);
  assign w_single   = !w_empty && (w_mask_clr == '0);
  assign w_emit     = (state_q == EMIT);

  // Mask is always zero in IDLE, so the index needs no state gating.
  assign in_ready  = !w_emit;
  assign out_valid = w_emit;
  assign out_idx   = w_idx;
  assign out_none  = w_emit && w_empty;
  assign out_last  = w_emit && (w_empty || w_single);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mask_q  <= in_vec;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              mask_q  <= '0;
              state_q <= IDLE;
            end else begin
              mask_q  <= w_mask_clr;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          mask_q  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_priority_encoder.sv
// ============================================================================
// tb_serial_priority_encoder : randomized self-checking bench with bit-list model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_priority_encoder;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_none;

  int n_vec  = 0;
  int n_fail = 0;

  serial_priority_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_none  (out_none)
  );

  always #5 clk = ~clk;

  // Reference: list of set-bit positions in ascending order; zero vector -> {0}.
  typedef int idx_q_t[$];
  function automatic idx_q_t model(input logic [N-1:0] v);
    idx_q_t q;
    for (int i = 0; i < N; i++) if (v[i]) q.push_back(i);
    if (q.size() == 0) q.push_back(0);
    return q;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, out_idx, out_last, out_none} !== {1'b1, 1'b0, W'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b idx=%0d last=%b none=%b, want rdy=1 vld=0 idx=0 last=0 none=0",
               in_ready, out_valid, out_idx, out_last, out_none);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Sends one vector and drains it; out_ready follows ready_pct (100 = always ready).
  // During EMIT in_valid is toggled with garbage to confirm it is ignored.
  task automatic test_vector(input string name, input logic [N-1:0] v, input int ready_pct);
    idx_q_t exp;
    int k;
    int cyc;
    logic rdy;
    exp = model(v);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: rdy=%b vld=%b, want rdy=1 vld=0", name, in_ready, out_valid);
    end
    in_valid = 1'b1; in_vec = v;
    @(negedge clk);
    k = 0; cyc = 0;
    while (k < exp.size() && cyc < 200) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_vec   = N'($urandom);
      rdy = ($urandom_range(1, 100) <= ready_pct);
      out_ready = rdy;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_idx !== W'(exp[k]) ||
          out_last !== (k == exp.size() - 1) || out_none !== (v == '0)) begin
        n_fail++;
        $display("FAIL %s beat %0d: vld=%b rdy=%b idx=%0d last=%b none=%b, want vld=1 rdy=0 idx=%0d last=%b none=%b",
                 name, k, out_valid, in_ready, out_idx, out_last, out_none,
                 exp[k], (k == exp.size() - 1), (v == '0));
      end
      if (rdy) k++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_vec++;
    if (cyc >= 200 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: vld=%b rdy=%b cyc=%0d, want vld=0 rdy=1", name, out_valid, in_ready, cyc);
    end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_vec = 8'b1000_0001; out_ready = 1'b0;
    @(negedge clk);
    in_vec = 8'b0011_1100;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_idx !== W'(0) || out_last !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure hold %0d: vld=%b idx=%0d last=%b rdy=%b, want vld=1 idx=0 last=0 rdy=0",
                 c, out_valid, out_idx, out_last, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_vec++;
    if (out_idx !== W'(0) || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure beat0: idx=%0d last=%b, want idx=0 last=0", out_idx, out_last);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== W'(7) || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure beat1: vld=%b idx=%0d last=%b, want vld=1 idx=7 last=1",
               out_valid, out_idx, out_last);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure end: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_idx !== W'(k)) begin
        n_fail++;
        $display("FAIL async_reset beat %0d: vld=%b idx=%0d, want vld=1 idx=%0d", k, out_valid, out_idx, k);
      end
      @(negedge clk);
    end
    // Mid-cycle: no clock edge between asserting rst and sampling.
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, out_valid, out_idx, out_last, out_none} !== {1'b1, 1'b0, W'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset immediate: rdy=%b vld=%b idx=%0d last=%b none=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, out_none);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL async_reset after %0d: vld=%b rdy=%b, want vld=0 rdy=1", c, out_valid, in_ready);
      end
    end
    test_vector("post_reset", 8'b0001_0000, 100);
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_vec = 8'b0000_0010; out_ready = 1'b1;
    @(negedge clk);
    in_vec = 8'b0100_0000;
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== W'(1) || out_last !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b first: vld=%b idx=%0d last=%b rdy=%b, want vld=1 idx=1 last=1 rdy=0",
               out_valid, out_idx, out_last, in_ready);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b idle gap: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_idx !== W'(6) || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b second: vld=%b idx=%0d last=%b, want vld=1 idx=6 last=1",
               out_valid, out_idx, out_last);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b end: vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int t = 0; t < 40; t++) begin
      v = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      test_vector("random", v, int'($urandom_range(30, 100)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_vector("single", 8'b0000_0100, 100);
    test_vector("multi", 8'b1010_0011, 100);
    test_vector("zero", 8'b0000_0000, 100);
    test_vector("top_bit", 8'b1000_0000, 100);
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/serial_priority_encoder.md
Name: serial_priority_encoder

Overview:
- Sequential N-to-log2(N) encoder; the inverse function of the team's 1x2/NxM decoders.
- Accepts an N-bit one-hot or multi-hot vector on a valid/ready input handshake.
- Emits the binary index of every set bit, lowest index first, one index per accepted output beat, with a last flag.
- Used where a decoded select/request bus must be turned back into a stream of indices (interrupt/request serialisation).

Parameters:
- N, 8, width of input vector; power of two, N >= 2.
- W, $clog2(N), width of output index; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector (high only in IDLE).
- in_vec  input  N  vector to encode.
- out_valid  output  1  out_idx/out_last/out_none valid.
- out_ready  input  1  downstream accepts current beat.
- out_idx  output  W  binary index of lowest remaining set bit; 0 when out_none.
- out_last  output  1  current beat is final beat for this vector.
- out_none  output  1  captured vector was all-zero (single beat, out_idx=0, out_last=1).

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_none=0. Internal mask=0, state=IDLE.
- Reset mid-operation discards the captured vector. No beat is emitted after rst deasserts until a new vector is accepted.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready at edge t: mask<=in_vec, state<=EMIT.
  - out_valid rises in cycle t+1 (latency 1).
- EMIT:
  - in_ready=0; in_valid is ignored and no overlap is permitted.
  - out_valid=1.
  - out_idx = index of lowest set bit of mask.
  - out_last=1 when mask has exactly one set bit.
  - out_none=1 when mask==0 (all-zero vector captured).
- Beat transfer occurs on out_valid&out_ready at a rising edge:
  - If out_last: mask<=0, state<=IDLE. in_ready returns high the next cycle.
  - Else: clear lowest set bit of mask and stay in EMIT. The next index appears the next cycle.
- Backpressure: while out_ready=0, out_idx/out_last/out_none hold stable and out_valid stays high.
- Throughput: a vector with k set bits takes k output beats (1 beat if zero) plus 1 IDLE cycle before the next vector is accepted.
- out_idx, out_last and out_none are functions of registered mask/state only. There is no combinational path from in_* or out_ready to out_*.
- Lowest-set-bit selection: priority from bit 0 upward. Bit N-1 yields out_idx=N-1 (all ones in W bits).
- No arithmetic overflow is possible. The index width W exactly covers 0..N-1.

Test Plan:
- Reset, then in_vec=8'b0000_0100 with in_valid pulse, out_ready=1 -> one beat: out_idx=2, out_last=1, out_none=0. out_valid high exactly one cycle. in_ready low for that cycle, high again after.
- in_vec=8'b1010_0011, out_ready=1 -> beats out_idx=0,1,5,7 on consecutive cycles; out_last=1 only on idx 7.
- in_vec=8'b0000_0000 -> single beat: out_none=1, out_idx=0, out_last=1. Then return to IDLE.
- in_vec=8'b1000_0001 with out_ready held low 3 cycles -> out_idx=0 stable, out_valid=1 throughout. After out_ready=1: idx 0 then idx 7 (last). A second in_valid during EMIT is not accepted (in_ready=0).
- in_vec=8'b1111_1111, assert rst asynchronously after 3 beats (idx 0,1,2) -> outputs go to reset values immediately without waiting for clk. After release: no further beats, in_ready=1. A new vector 8'b0001_0000 yields idx 4, last.
- Back-to-back vectors 8'b0000_0010 then 8'b0100_0000 with in_valid held high -> idx 1 (last), one IDLE cycle, then idx 6 (last).
